// File: rtl/pb_key_fifo_bridge_if.sv
// Producer/consumer kcpsm6 port bundle for the key FIFO bridge; slave = bridge, master = cores/board.
// Latency: wires only. Backpressure: none (status byte reports full/empty; KEY_WATERMARK_EN adds interrupt pair).
interface pb_key_fifo_bridge_if #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int NUM_EXT = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [7:0]                  prod_port_id;
    logic [DATA_W-1:0]           prod_out_port;
    logic                        prod_write_strobe;
    logic [DATA_W-1:0]           prod_in_port;
    logic [7:0]                  cons_port_id;
    logic                        cons_read_strobe;
    logic [DATA_W-1:0]           cons_in_port;
    logic [NUM_EXT*DATA_W-1:0]   ext_in;
    logic [CNT_W-1:0]            fifo_count;
`ifdef KEY_WATERMARK_EN
    logic                        prod_interrupt;
    logic                        prod_interrupt_ack;

    modport master (
        output prod_port_id, prod_out_port, prod_write_strobe,
        output cons_port_id, cons_read_strobe, ext_in, prod_interrupt_ack,
        input  prod_in_port, cons_in_port, fifo_count, prod_interrupt
    );
    modport slave (
        input  prod_port_id, prod_out_port, prod_write_strobe,
        input  cons_port_id, cons_read_strobe, ext_in, prod_interrupt_ack,
        output prod_in_port, cons_in_port, fifo_count, prod_interrupt
    );
`else
    modport master (
        output prod_port_id, prod_out_port, prod_write_strobe,
        output cons_port_id, cons_read_strobe, ext_in,
        input  prod_in_port, cons_in_port, fifo_count
    );
    modport slave (
        input  prod_port_id, prod_out_port, prod_write_strobe,
        input  cons_port_id, cons_read_strobe, ext_in,
        output prod_in_port, cons_in_port, fifo_count
    );
`endif
endinterface

// File: rtl/pb_key_fifo_bridge.sv
// Key-byte FIFO between two kcpsm6 cores plus the consumer's registered in_port mux (FIFO head/status/ext).
// Latency: 1 cycle port_id -> cons_in_port/prod_in_port; FIFO head is fall-through. Optional KEY_WATERMARK_EN.
// Backpressure: none; push when full drops + sets sticky overflow, pop when empty returns 0 + sets underflow.
module pb_key_fifo_bridge #(
    parameter int         DATA_W      = 8,
    parameter int         DEPTH       = 16,
    parameter int         NUM_EXT     = 4,
    parameter logic [7:0] KEY_WR_PORT = 8'h01,
    parameter logic [7:0] CTRL_PORT   = 8'h02,
    parameter logic [7:0] KEY_RD_PORT = 8'h10,
    parameter logic [7:0] STAT_PORT   = 8'h11,
    parameter logic [7:0] EXT_BASE    = 8'h20
`ifdef KEY_WATERMARK_EN
    ,
    parameter int         LOW_WM      = 4
`endif
) (
    input logic                 clk,
    input logic                 reset,
    pb_key_fifo_bridge_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              overflow, underflow;
    logic              full, empty;
    logic              push_req, pop_req, ctrl_wr, flush, push_ok, pop_ok;
    logic              ovf_set, unf_set, ovf_clr, unf_clr;
    logic [3:0]        cnt_sat;
    logic [7:0]        status;
    logic [DATA_W-1:0] status_dat, cons_mux;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_req = bus.prod_write_strobe && (bus.prod_port_id == KEY_WR_PORT);
    assign ctrl_wr  = bus.prod_write_strobe && (bus.prod_port_id == CTRL_PORT);
    assign flush    = ctrl_wr && bus.prod_out_port[7];
    assign pop_req  = bus.cons_read_strobe && (bus.cons_port_id == KEY_RD_PORT);

    // A pop frees the slot a full-FIFO push needs; flush overrides both sides.
    assign pop_ok   = pop_req && !empty && !flush;
    assign push_ok  = push_req && !flush && (!full || pop_ok);
    assign ovf_set  = push_req && !flush && !push_ok;
    assign unf_set  = pop_req && !flush && empty;
    assign ovf_clr  = ctrl_wr && bus.prod_out_port[0];
    assign unf_clr  = ctrl_wr && bus.prod_out_port[1];

    always_comb begin
        cnt_sat = (32'(count) > 15) ? 4'hF : 4'(count);
    end

    assign status         = {full, empty, overflow, underflow, cnt_sat};
    assign status_dat     = DATA_W'(status);
    assign bus.fifo_count = count;

    always_comb begin
        cons_mux = '0;
        if (bus.cons_port_id == KEY_RD_PORT) begin
            cons_mux = empty ? '0 : mem[rd_ptr];
        end else if (bus.cons_port_id == STAT_PORT) begin
            cons_mux = status_dat;
        end else begin
            for (int i = 0; i < NUM_EXT; i++) begin
                if (bus.cons_port_id == 8'(int'(EXT_BASE) + i)) begin
                    cons_mux = bus.ext_in[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.prod_out_port;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
            bus.prod_in_port <= DATA_W'(8'h40);
            bus.cons_in_port <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
                if (push_ok && !pop_ok)      count <= count + CW'(1);
                else if (!push_ok && pop_ok) count <= count - CW'(1);
            end
            // Set beats a same-cycle clear so no event is ever lost.
            overflow         <= ovf_set || (overflow && !ovf_clr);
            underflow        <= unf_set || (underflow && !unf_clr);
            bus.prod_in_port <= status_dat;
            bus.cons_in_port <= cons_mux;
        end
    end

`ifdef KEY_WATERMARK_EN
    typedef enum logic [1:0] {WM_DISARMED, WM_ARMED, WM_FIRED} wm_state_t;
    wm_state_t wm_state, wm_next;

    always_ff @(posedge clk) begin
        if (reset) wm_state <= WM_DISARMED;
        else       wm_state <= wm_next;
    end

    // Starts disarmed: the empty FIFO after reset must not raise a refill request.
    always_comb begin
        wm_next = wm_state;
        case (wm_state)
            WM_DISARMED: if (32'(count) >= LOW_WM) wm_next = WM_ARMED;
            WM_ARMED:    if (32'(count) <  LOW_WM) wm_next = WM_FIRED;
            WM_FIRED:    if (bus.prod_interrupt_ack) wm_next = WM_DISARMED;
            default:     wm_next = WM_DISARMED;
        endcase
    end

    always_comb begin
        bus.prod_interrupt = (wm_state == WM_FIRED);
    end
`endif
endmodule
